// File: rtl/scr1_tcm_pkg.sv
// Shared TCM port types: command, access width and response encodings,
// plus the byte-lane helpers used by both TCM port controllers.
package scr1_tcm_pkg;

   localparam int unsigned SCR1_TCM_DWIDTH = 64;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'd0,
      SCR1_MEM_WIDTH_HWORD = 2'd1,
      SCR1_MEM_WIDTH_WORD  = 2'd2,
      SCR1_MEM_WIDTH_DWORD = 2'd3
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_IDLE  = 2'd0,
      SCR1_MEM_RESP_OKAY  = 2'd1,
      SCR1_MEM_RESP_ERROR = 2'd2
   } type_scr1_mem_resp_e;

   // Unshifted byte mask covering one access of the given width.
   function automatic logic [7:0] scr1_byte_mask(input type_scr1_mem_width_e width);
      logic [7:0] mask;
      mask = 8'hFF;
      case (width)
         SCR1_MEM_WIDTH_BYTE  : mask = 8'h01;
         SCR1_MEM_WIDTH_HWORD : mask = 8'h03;
         SCR1_MEM_WIDTH_WORD  : mask = 8'h0F;
         default              : mask = 8'hFF;
      endcase
      return mask;
   endfunction

   function automatic logic scr1_misaligned(input type_scr1_mem_width_e width,
                                            input logic [2:0]           offset);
      logic mis;
      mis = 1'b0;
      case (width)
         SCR1_MEM_WIDTH_BYTE  : mis = 1'b0;
         SCR1_MEM_WIDTH_HWORD : mis = offset[0];
         SCR1_MEM_WIDTH_WORD  : mis = |offset[1:0];
         default              : mis = |offset;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/scr1_tcm_lane_align.sv
// Byte-lane steering between LSB-justified core data and the 64-bit TCM word:
// write shift and byte enables on the request side, read extract on the response side.
module scr1_tcm_lane_align
   import scr1_tcm_pkg::*;
(
   input  type_scr1_mem_width_e wr_width,
   input  logic [2:0]           wr_offset,
   input  logic [63:0]          wr_data,
   output logic [63:0]          wr_data_shifted,
   output logic [7:0]           wr_byte_en,
   input  type_scr1_mem_width_e rd_width,
   input  logic [2:0]           rd_offset,
   input  logic [63:0]          rd_word,
   output logic [63:0]          rd_data
);

   logic [63:0] rd_shifted;

   always_comb begin
      wr_data_shifted = wr_data << {wr_offset, 3'b000};
      wr_byte_en      = scr1_byte_mask(wr_width) << wr_offset;
   end

   // Extracted lanes are zero-extended; upper bytes never leak through.
   always_comb begin
      rd_shifted = rd_word >> {rd_offset, 3'b000};
      rd_data    = rd_shifted;
      case (rd_width)
         SCR1_MEM_WIDTH_BYTE  : rd_data = {56'd0, rd_shifted[7:0]};
         SCR1_MEM_WIDTH_HWORD : rd_data = {48'd0, rd_shifted[15:0]};
         SCR1_MEM_WIDTH_WORD  : rd_data = {32'd0, rd_shifted[31:0]};
         default              : rd_data = rd_shifted;
      endcase
   end

endmodule

// File: rtl/scr1_tcm_dport_ctrl.sv
// TCM data-port initiator: accepts one LSU request per cycle, drives RAM port B
// in the same cycle and returns OKAY/ERROR plus read data exactly one cycle later.
module scr1_tcm_dport_ctrl
   import scr1_tcm_pkg::*;
#(
   parameter logic [31:0] TCM_SIZE = 32'h0001_0000,
   parameter logic [31:0] TCM_BASE = 32'h0048_0000,
   parameter int unsigned DWIDTH   = SCR1_TCM_DWIDTH
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        dmem_req,
   input  logic                        dmem_cmd,
   input  logic [1:0]                  dmem_width,
   input  logic [31:0]                 dmem_addr,
   input  logic [DWIDTH-1:0]           dmem_wdata,
   output logic                        dmem_req_ack,
   output logic [DWIDTH-1:0]           dmem_rdata,
   output logic [1:0]                  dmem_resp,
   output logic                        mem_renb,
   output logic                        mem_wenb,
   output logic [7:0]                  mem_webb,
   output logic [$clog2(TCM_SIZE)-4:0] mem_addrb,
   output logic [DWIDTH-1:0]           mem_datab,
   input  logic [DWIDTH-1:0]           mem_qb
);

   localparam int unsigned TCM_AW = $clog2(TCM_SIZE);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   type_scr1_mem_cmd_e   req_cmd;
   type_scr1_mem_width_e req_width;
   logic [2:0]           req_offset;
   logic                 req_accept;
   logic                 req_misalign;
   logic                 req_out_of_range;
   logic                 req_err;
   logic [7:0]           wr_byte_en;
   logic [63:0]          rd_extract;

   state_e               state_q,  state_d;
   type_scr1_mem_resp_e  resp_q,   resp_d;
   type_scr1_mem_cmd_e   cmd_q,    cmd_d;
   type_scr1_mem_width_e width_q,  width_d;
   logic [2:0]           offset_q, offset_d;
   logic                 err_q,    err_d;

   assign req_cmd    = type_scr1_mem_cmd_e'(dmem_cmd);
   assign req_width  = type_scr1_mem_width_e'(dmem_width);
   assign req_offset = dmem_addr[2:0];

   scr1_tcm_lane_align u_lane_align (
      .wr_width        (req_width),
      .wr_offset       (req_offset),
      .wr_data         (dmem_wdata),
      .wr_data_shifted (mem_datab),
      .wr_byte_en      (wr_byte_en),
      .rd_width        (width_q),
      .rd_offset       (offset_q),
      .rd_word         (mem_qb),
      .rd_data         (rd_extract)
   );

   // rst_n gates acceptance so no RAM enable can fire while the block is held in reset.
   always_comb begin
      dmem_req_ack     = rst_n;
      req_accept       = dmem_req & rst_n;
      req_misalign     = scr1_misaligned(req_width, req_offset);
      req_out_of_range = dmem_addr[31:TCM_AW] != TCM_BASE[31:TCM_AW];
      req_err          = req_misalign | req_out_of_range;
      mem_renb         = req_accept & (req_cmd == SCR1_MEM_CMD_RD) & ~req_err;
      mem_wenb         = req_accept & (req_cmd == SCR1_MEM_CMD_WR) & ~req_err;
      mem_webb         = mem_wenb ? wr_byte_en : 8'h00;
      mem_addrb        = dmem_addr[TCM_AW-1:3];
   end

   always_comb begin
      state_d  = req_accept ? ST_RESP : ST_IDLE;
      resp_d   = SCR1_MEM_RESP_IDLE;
      cmd_d    = cmd_q;
      width_d  = width_q;
      offset_d = offset_q;
      err_d    = err_q;
      if (req_accept) begin
         resp_d   = req_err ? SCR1_MEM_RESP_ERROR : SCR1_MEM_RESP_OKAY;
         cmd_d    = req_cmd;
         width_d  = req_width;
         offset_d = req_offset;
         err_d    = req_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         resp_q   <= SCR1_MEM_RESP_IDLE;
         cmd_q    <= SCR1_MEM_CMD_RD;
         width_q  <= SCR1_MEM_WIDTH_BYTE;
         offset_q <= 3'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         resp_q   <= resp_d;
         cmd_q    <= cmd_d;
         width_q  <= width_d;
         offset_q <= offset_d;
         err_q    <= err_d;
      end
   end

   // Read data is steered straight from the RAM output in the response cycle.
   always_comb begin
      dmem_resp  = resp_q;
      dmem_rdata = '0;
      if ((state_q == ST_RESP) && !err_q && (cmd_q == SCR1_MEM_CMD_RD)) begin
         dmem_rdata = rd_extract;
      end
   end

endmodule

// File: tb/tb_scr1_tcm_dport_ctrl.sv
// Scoreboard bench for the TCM data-port controller: a byte-addressed reference
// memory predicts every response, a monitor pops and compares one cycle later.
module tb_scr1_tcm_dport_ctrl;
   import scr1_tcm_pkg::*;

   localparam logic [31:0] TCM_SIZE = 32'h0001_0000;
   localparam logic [31:0] TCM_BASE = 32'h0048_0000;
   localparam int          ADDRB_W  = $clog2(TCM_SIZE) - 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               dmem_req;
   logic               dmem_cmd;
   logic [1:0]         dmem_width;
   logic [31:0]        dmem_addr;
   logic [63:0]        dmem_wdata;
   logic               dmem_req_ack;
   logic [63:0]        dmem_rdata;
   logic [1:0]         dmem_resp;
   logic               mem_renb;
   logic               mem_wenb;
   logic [7:0]         mem_webb;
   logic [ADDRB_W-1:0] mem_addrb;
   logic [63:0]        mem_datab;
   logic [63:0]        mem_qb;

   typedef struct {
      logic [1:0]  resp;
      logic [63:0] rdata;
      string       tag;
   } exp_t;

   exp_t        expQ[$];
   logic [7:0]  refMem[int];
   logic [63:0] ram[int];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   scr1_tcm_dport_ctrl #(
      .TCM_SIZE (TCM_SIZE),
      .TCM_BASE (TCM_BASE),
      .DWIDTH   (64)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dmem_req     (dmem_req),
      .dmem_cmd     (dmem_cmd),
      .dmem_width   (dmem_width),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_req_ack (dmem_req_ack),
      .dmem_rdata   (dmem_rdata),
      .dmem_resp    (dmem_resp),
      .mem_renb     (mem_renb),
      .mem_wenb     (mem_wenb),
      .mem_webb     (mem_webb),
      .mem_addrb    (mem_addrb),
      .mem_datab    (mem_datab),
      .mem_qb       (mem_qb)
   );

   // TCM RAM port B: byte-masked write, one-cycle registered read.
   always @(posedge clk) begin : ramModel
      logic [63:0] word;
      int          idx;
      idx = int'(mem_addrb);
      if (mem_wenb === 1'b1) begin
         word = ram.exists(idx) ? ram[idx] : 64'd0;
         for (int i = 0; i < 8; i++) begin
            if (mem_webb[i]) word[8*i +: 8] = mem_datab[8*i +: 8];
         end
         ram[idx] = word;
      end
      if (mem_renb === 1'b1) mem_qb <= ram.exists(idx) ? ram[idx] : 64'd0;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] refRead(input int off, input int n);
      logic [63:0] v;
      v = 64'd0;
      for (int i = 0; i < n; i++) begin
         if (refMem.exists(off + i)) v[8*i +: 8] = refMem[off + i];
      end
      return v;
   endfunction

   // Drives one request at the falling edge, checks the same-cycle RAM drive,
   // and queues the response the reference memory predicts for the next cycle.
   task automatic applyStimulus(input bit isWr, input int w, input logic [31:0] addr,
                                input logic [63:0] wdata, input bit expectResp, input string tag);
      int         n;
      int         off;
      int         rel;
      bit         misalign;
      bit         inRange;
      bit         err;
      logic [7:0] expWebb;
      exp_t       e;
      @(negedge clk);
      dmem_req   = 1'b1;
      dmem_cmd   = isWr;
      dmem_width = w[1:0];
      dmem_addr  = addr;
      dmem_wdata = wdata;
      #1;
      n        = 1 << w;
      off      = int'(addr[2:0]);
      misalign = (off % n) != 0;
      inRange  = (addr >= TCM_BASE) && ((addr - TCM_BASE) < TCM_SIZE);
      err      = misalign || !inRange;
      rel      = int'(addr - TCM_BASE);
      expWebb  = 8'h00;
      if (isWr && !err) begin
         for (int i = 0; i < n; i++) expWebb[off + i] = 1'b1;
      end
      checkOutput({tag, " ack"},  64'(dmem_req_ack), 64'd1);
      checkOutput({tag, " renb"}, 64'(mem_renb), 64'(!isWr && !err));
      checkOutput({tag, " wenb"}, 64'(mem_wenb), 64'(isWr && !err));
      checkOutput({tag, " webb"}, 64'(mem_webb), 64'(expWebb));
      if (!err) checkOutput({tag, " addrb"}, 64'(mem_addrb), 64'(rel >> 3));
      if (isWr) checkOutput({tag, " datab"}, mem_datab, wdata << (8 * off));
      e.tag = tag;
      if (err) begin
         e.resp  = 2'd2;
         e.rdata = 64'd0;
      end else if (isWr) begin
         e.resp  = 2'd1;
         e.rdata = 64'd0;
         for (int i = 0; i < n; i++) refMem[rel + i] = wdata[8*i +: 8];
      end else begin
         e.resp  = 2'd1;
         e.rdata = refRead(rel, n);
      end
      if (expectResp) expQ.push_back(e);
   endtask

   task automatic idleCycle();
      @(negedge clk);
      dmem_req   = 1'b0;
      dmem_cmd   = 1'($urandom);
      dmem_width = 2'($urandom);
      dmem_addr  = $urandom;
      dmem_wdata = {$urandom, $urandom};
   endtask

   function automatic logic [31:0] randAddr(input int w);
      int          sel;
      logic [31:0] off;
      logic [31:0] mask;
      sel  = int'($urandom_range(0, 9));
      off  = $urandom_range(0, 63);
      mask = 32'((1 << w) - 1);
      if (sel < 7) return TCM_BASE + (off & ~mask);
      if (sel == 7) return TCM_BASE + off;
      if (sel == 8) return TCM_BASE + TCM_SIZE + off;
      return TCM_BASE - 32'd64 + off;
   endfunction

   // Monitor: every cycle after the active edge, a queued response must be on the port
   // and nothing may appear when none is queued.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.tag, " resp"},  64'(dmem_resp), 64'(e.resp));
            checkOutput({e.tag, " rdata"}, dmem_rdata, e.rdata);
         end else if (dmem_resp !== 2'd0) begin
            checkOutput("unexpected resp", 64'(dmem_resp), 64'd0);
         end
      end
   end

   initial begin : stimulus
      int w;
      rst_n      = 1'b0;
      dmem_req   = 1'b0;
      dmem_cmd   = 1'b0;
      dmem_width = 2'd0;
      dmem_addr  = 32'd0;
      dmem_wdata = 64'd0;
      repeat (2) @(negedge clk);
      checkOutput("reset ack",   64'(dmem_req_ack), 64'd0);
      checkOutput("reset resp",  64'(dmem_resp), 64'd0);
      checkOutput("reset rdata", dmem_rdata, 64'd0);
      checkOutput("reset renb",  64'(mem_renb), 64'd0);
      checkOutput("reset wenb",  64'(mem_wenb), 64'd0);
      checkOutput("reset webb",  64'(mem_webb), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("ack after reset", 64'(dmem_req_ack), 64'd1);

      applyStimulus(1'b1, 3, TCM_BASE + 32'h10, 64'h1122334455667788, 1'b1, "dword wr");
      applyStimulus(1'b0, 3, TCM_BASE + 32'h10, 64'd0, 1'b1, "dword rd");
      applyStimulus(1'b1, 0, TCM_BASE + 32'h13, 64'h00000000000000AB, 1'b1, "byte wr");
      applyStimulus(1'b0, 2, TCM_BASE + 32'h10, 64'd0, 1'b1, "word rd");
      applyStimulus(1'b0, 1, TCM_BASE + 32'h03, 64'd0, 1'b1, "misaligned half");
      applyStimulus(1'b0, 2, TCM_BASE + TCM_SIZE, 64'd0, 1'b1, "out of range");
      applyStimulus(1'b1, 2, TCM_BASE - 32'h4, 64'h0000_0000_CAFE_F00D, 1'b1, "below base");
      applyStimulus(1'b1, 3, TCM_BASE + 32'h00, 64'hA5A5_0F0F_1234_5678, 1'b1, "fill lo");
      applyStimulus(1'b1, 3, TCM_BASE + 32'h08, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, "fill hi");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 2, TCM_BASE + 32'(4 * k), 64'd0, 1'b1, "b2b word rd");
      end
      idleCycle();

      applyStimulus(1'b0, 2, TCM_BASE + 32'h10, 64'd0, 1'b0, "reset rd");
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("mid-reset resp",  64'(dmem_resp), 64'd0);
      checkOutput("mid-reset rdata", dmem_rdata, 64'd0);
      checkOutput("mid-reset ack",   64'(dmem_req_ack), 64'd0);
      checkOutput("mid-reset renb",  64'(mem_renb), 64'd0);
      dmem_cmd = 1'b1;
      #1;
      checkOutput("mid-reset wenb", 64'(mem_wenb), 64'd0);
      checkOutput("mid-reset webb", 64'(mem_webb), 64'd0);
      @(negedge clk);
      dmem_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #3;
      checkOutput("post-reset resp", 64'(dmem_resp), 64'd0);

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 4) == 0) begin
            idleCycle();
         end else begin
            w = int'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), w, randAddr(w), {$urandom, $urandom}, 1'b1, "rand");
         end
      end
      idleCycle();
      idleCycle();
      checkOutput("queue drained", 64'(expQ.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
